// File: rtl/fp_pkg.sv
// Shared constants and pipeline record types for the floating-point add/sub pipeline.
package fp_pkg;

  // Guard, round and sticky bits appended below the significand LSB.
  localparam int GRS_W = 3;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_ones(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic sign;
    logic sub;
    logic special;
    logic nan;
  } stage_ctl_t;

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W     = 27,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     i_vec,
  output logic [CNT_W-1:0] o_cnt
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    o_cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) o_cnt = CNT_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/float_pt_add_sub_pipe.sv
// 3-stage pipelined floating-point add/sub: align, add + LZC, normalise + round-to-nearest-even.
module float_pt_add_sub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s_a,
  input  logic [EXP_W-1:0] e_a,
  input  logic [MAN_W-1:0] m_a,
  input  logic             s_b,
  input  logic [EXP_W-1:0] e_b,
  input  logic [MAN_W-1:0] m_b,
  input  logic             oper,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s_op,
  output logic [EXP_W-1:0] e_op,
  output logic [MAN_W-1:0] m_op,
  output logic             ovf,
  output logic             unf
);

  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = SIG_W + GRS_W;
  localparam int SUM_W = EXT_W + 1;
  localparam int LZ_W  = $clog2(EXT_W + 1);
  localparam int XW    = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(exp_ones(EXP_W));

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [EXP_W-1:0] exp;
    logic [SUM_W-1:0] sig;
  } stage_t;

  stage_t            r_s1, r_s2;
  logic [EXT_W-1:0]  r_s1_small;
  logic [LZ_W-1:0]   r_s2_lzc;
  logic              r_out_valid, r_s_op, r_ovf, r_unf;
  logic [EXP_W-1:0]  r_e_op;
  logic [MAN_W-1:0]  r_m_op;

  logic w_stall;
  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // ---------------- Stage 1: decode, swap, align ----------------
  logic             w_eff_sb, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_ge;
  logic             w_special, w_nan;
  logic [SIG_W-1:0] w_sig_a, w_sig_b, w_sig_small;
  logic [EXP_W-1:0] w_diff;
  logic [EXT_W-1:0] w_small_ext, w_shift_mask, w_small_al;
  stage_t           w_s1;

  assign w_eff_sb    = s_b ^ ~oper;
  assign w_a_zero    = (e_a == '0);
  assign w_b_zero    = (e_b == '0);
  assign w_a_inf     = (e_a == EXP_MAX);
  assign w_b_inf     = (e_b == EXP_MAX);
  assign w_sig_a     = w_a_zero ? '0 : {1'b1, m_a};
  assign w_sig_b     = w_b_zero ? '0 : {1'b1, m_b};
  assign w_a_ge      = {e_a, w_sig_a} >= {e_b, w_sig_b};
  assign w_sig_small = w_a_ge ? w_sig_b : w_sig_a;
  assign w_diff      = w_a_ge ? e_a - e_b : e_b - e_a;
  assign w_special   = w_a_inf | w_b_inf;
  assign w_nan       = w_a_inf & w_b_inf & (s_a ^ w_eff_sb);

  // Bits shifted past the sticky position are OR-ed back into it.
  assign w_small_ext  = {w_sig_small, {GRS_W{1'b0}}};
  assign w_shift_mask = ~({EXT_W{1'b1}} << w_diff);
  assign w_small_al   = (w_small_ext >> w_diff)
                      | {{(EXT_W-1){1'b0}}, |(w_small_ext & w_shift_mask)};

  always_comb begin
    w_s1             = '0;
    w_s1.ctl.valid   = in_valid;
    w_s1.ctl.sub     = s_a ^ w_eff_sb;
    w_s1.ctl.special = w_special;
    w_s1.ctl.nan     = w_nan;
    if (w_special) w_s1.ctl.sign = w_nan ? 1'b0 : (w_a_inf ? s_a : w_eff_sb);
    else           w_s1.ctl.sign = w_a_ge ? s_a : w_eff_sb;
    w_s1.exp = w_a_ge ? e_a : e_b;
    w_s1.sig = {1'b0, (w_a_ge ? w_sig_a : w_sig_b), {GRS_W{1'b0}}};
  end

  // ---------------- Stage 2: add/sub + leading-zero count ----------------
  logic [SUM_W-1:0] w_sum;
  logic [LZ_W-1:0]  w_lzc;
  stage_t           w_s2;

  assign w_sum = r_s1.ctl.sub ? r_s1.sig - {1'b0, r_s1_small}
                              : r_s1.sig + {1'b0, r_s1_small};

  fp_lzc #(.W(EXT_W)) u_lzc (
    .i_vec (w_sum[EXT_W-1:0]),
    .o_cnt (w_lzc)
  );

  always_comb begin
    w_s2     = r_s1;
    w_s2.sig = w_sum;
  end

  // ---------------- Stage 3: normalise, round, classify ----------------
  logic             w_carry, w_zero, w_rnd_up, w_exp_neg, w_exp_big;
  logic [EXT_W-1:0] w_norm;
  logic [SIG_W:0]   w_mant_rnd;
  logic [MAN_W-1:0] w_frac;
  logic [XW-1:0]    w_exp_base, w_exp_pre, w_exp_fin;
  logic             w_res_s, w_ovf, w_unf;
  logic [EXP_W-1:0] w_res_e;
  logic [MAN_W-1:0] w_res_m;

  assign w_carry    = r_s2.sig[SUM_W-1];
  assign w_zero     = (r_s2.sig == '0);
  assign w_norm     = w_carry ? {r_s2.sig[SUM_W-1:2], |r_s2.sig[1:0]}
                              : r_s2.sig[EXT_W-1:0] << r_s2_lzc;
  assign w_exp_base = {2'b00, r_s2.exp};
  assign w_exp_pre  = w_carry ? w_exp_base + XW'(1) : w_exp_base - XW'(r_s2_lzc);
  assign w_rnd_up   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mant_rnd = {1'b0, w_norm[EXT_W-1:GRS_W]} + (SIG_W+1)'(w_rnd_up);
  assign w_frac     = w_mant_rnd[SIG_W] ? w_mant_rnd[MAN_W:1] : w_mant_rnd[MAN_W-1:0];
  assign w_exp_fin  = w_exp_pre + XW'(w_mant_rnd[SIG_W]);
  assign w_exp_neg  = w_exp_fin[XW-1] | (w_exp_fin == '0);
  assign w_exp_big  = ~w_exp_fin[XW-1] & (w_exp_fin[XW-2:0] >= {1'b0, EXP_MAX});

  always_comb begin
    w_res_s = r_s2.ctl.sign;
    w_res_e = w_exp_fin[EXP_W-1:0];
    w_res_m = w_frac;
    w_ovf   = 1'b0;
    w_unf   = 1'b0;
    if (r_s2.ctl.special) begin
      w_res_e = EXP_MAX;
      w_res_m = r_s2.ctl.nan ? MAN_W'(1) : '0;
    end else if (w_zero) begin
      // An exact zero keeps a negative sign only when two like-signed zeros were added.
      w_res_s = r_s2.ctl.sign & ~r_s2.ctl.sub;
      w_res_e = '0;
      w_res_m = '0;
    end else if (w_exp_big) begin
      w_res_e = EXP_MAX;
      w_res_m = '0;
      w_ovf   = 1'b1;
    end else if (w_exp_neg) begin
      w_res_e = '0;
      w_res_m = '0;
      w_unf   = 1'b1;
    end
  end

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1        <= '0;
      r_s1_small  <= '0;
      r_s2        <= '0;
      r_s2_lzc    <= '0;
      r_out_valid <= 1'b0;
      r_s_op      <= 1'b0;
      r_e_op      <= '0;
      r_m_op      <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else if (!w_stall) begin
      r_s1        <= w_s1;
      r_s1_small  <= w_small_al;
      r_s2        <= w_s2;
      r_s2_lzc    <= w_lzc;
      r_out_valid <= r_s2.ctl.valid;
      r_s_op      <= w_res_s;
      r_e_op      <= w_res_e;
      r_m_op      <= w_res_m;
      r_ovf       <= r_s2.ctl.valid & w_ovf;
      r_unf       <= r_s2.ctl.valid & w_unf;
    end
  end

  assign out_valid = r_out_valid;
  assign s_op      = r_s_op;
  assign e_op      = r_e_op;
  assign m_op      = r_m_op;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule
